// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART transmit constants and state encoding
package uart_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_BIT_IDX_W = $clog2(UART_DATA_BITS);

    typedef logic [1:0] uart_state_t;

    localparam uart_state_t IDLE  = 2'd0;
    localparam uart_state_t START = 2'd1;
    localparam uart_state_t DATA  = 2'd2;
    localparam uart_state_t STOP  = 2'd3;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock show-ahead FIFO with occupancy count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset,
    input  logic                   i_Push,
    input  logic [WIDTH-1:0]       i_Data,
    input  logic                   i_Pop,
    output logic [WIDTH-1:0]       o_Data,
    output logic                   o_Full,
    output logic                   o_Empty,
    output logic [$clog2(DEPTH):0] o_Count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Guard against overflow/underflow here so callers may pulse freely
    assign o_Full  = (o_Count == (PW+1)'(DEPTH));
    assign o_Empty = (o_Count == '0);
    assign do_push = i_Push && !o_Full;
    assign do_pop  = i_Pop && !o_Empty;
    assign o_Data  = mem[rd_ptr];

    // Storage write; contents need no reset because pointers define validity
    always_ff @(posedge i_Clock) begin
        if (do_push) begin
            mem[wr_ptr] <= i_Data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_Count <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   o_Count <= o_Count + 1'b1;
                2'b01:   o_Count <= o_Count - 1'b1;
                default: o_Count <= o_Count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered 8N1 UART transmitter
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        i_Clock,
    input  logic                        i_Reset,
    input  logic                        i_Tx_DV,
    input  logic [UART_DATA_BITS-1:0]   i_Tx_Byte,
    output logic                        o_Tx_Ready,
    output logic                        o_Tx_Serial,
    output logic                        o_Tx_Active,
    output logic                        o_Tx_Done,
    output logic [$clog2(FIFO_DEPTH):0] o_Fifo_Count
);

    localparam int                        CCW      = $clog2(CLKS_PER_BIT);
    localparam logic [CCW-1:0]            CLK_LAST = CCW'(CLKS_PER_BIT - 1);
    localparam logic [UART_BIT_IDX_W-1:0] BIT_LAST = UART_BIT_IDX_W'(UART_DATA_BITS - 1);

    uart_state_t                 state;
    uart_state_t                 next_state;
    logic [CCW-1:0]              clk_cnt;
    logic [UART_BIT_IDX_W-1:0]   bit_idx;
    logic [UART_DATA_BITS-1:0]   shift;
    logic [UART_DATA_BITS-1:0]   fifo_head;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        pop;
    logic                        bit_end;
    logic                        last_bit;

    assign o_Tx_Ready = !fifo_full;
    assign bit_end    = (clk_cnt == CLK_LAST);
    assign last_bit   = (bit_idx == BIT_LAST);

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .i_Push  (i_Tx_DV && o_Tx_Ready),
        .i_Data  (i_Tx_Byte),
        .i_Pop   (pop),
        .o_Data  (fifo_head),
        .o_Full  (fifo_full),
        .o_Empty (fifo_empty),
        .o_Count (o_Fifo_Count)
    );

    // State register; async reset forces IDLE so the line goes high at once
    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: STOP chains straight into START when more bytes are queued
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!fifo_empty) next_state = START;
            START:   if (bit_end) next_state = DATA;
            DATA:    if (bit_end && last_bit) next_state = STOP;
            STOP:    if (bit_end) next_state = fifo_empty ? IDLE : START;
            default: next_state = IDLE;
        endcase
    end

    // Outputs and pop request decoded from the current state and bit timer
    always_comb begin
        o_Tx_Serial = 1'b1;
        o_Tx_Active = 1'b1;
        o_Tx_Done   = 1'b0;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                o_Tx_Active = 1'b0;
                pop         = !fifo_empty;
            end
            START:   o_Tx_Serial = 1'b0;
            DATA:    o_Tx_Serial = shift[bit_idx];
            STOP: begin
                o_Tx_Done = bit_end;
                pop       = bit_end && !fifo_empty;
            end
            default: o_Tx_Active = 1'b0;
        endcase
    end

    // Bit timer, bit index and shift register; a pop restarts the frame timing
    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else if (pop) begin
            shift   <= fifo_head;
            clk_cnt <= '0;
            bit_idx <= '0;
        end else if (state == IDLE) begin
            clk_cnt <= '0;
        end else if (bit_end) begin
            clk_cnt <= '0;
            if (state == DATA) begin
                bit_idx <= bit_idx + 1'b1;
            end
        end else begin
            clk_cnt <= clk_cnt + 1'b1;
        end
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Serial transmit stage directly downstream of DMA_controller_IO.
- Accepts bytes on the DMA's byte/valid interface (o_uart_tx / o_uart_tx_dv) into a small FIFO.
- Serialises each byte as 8N1 UART frames on o_Tx_Serial, so the DMA can burst several bytes without waiting per frame.
- Reports done and ready status back to the DMA.

Parameters:
- CLKS_PER_BIT, 87, clock cycles per UART bit (e.g. 10 MHz / 115200). Legal range 2..65535.
- FIFO_DEPTH, 4, byte entries in the transmit FIFO. Power of two, 2..16.

Ports:
- i_Clock  in  1  system clock, all logic on rising edge
- i_Reset  in  1  asynchronous, active-low reset (0 = reset)
- i_Tx_DV  in  1  byte valid from DMA, one-cycle pulse per byte
- i_Tx_Byte  in  8  byte to transmit, sampled when i_Tx_DV=1
- o_Tx_Ready  out  1  FIFO not full; a push is accepted only when this is 1
- o_Tx_Serial  out  1  UART line, idle high
- o_Tx_Active  out  1  high while a frame (start..stop) is on the line
- o_Tx_Done  out  1  one-cycle pulse on the final cycle of each stop bit
- o_Fifo_Count  out  $clog2(FIFO_DEPTH)+1  bytes currently queued, excluding the byte in flight

Behaviour:
- Reset values (i_Reset low, asynchronous): o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Tx_Ready=1, o_Fifo_Count=0, state=IDLE, bit counter=0, clock counter=0, FIFO pointers=0.
- Reset during a frame aborts it: line returns high immediately and FIFO contents are discarded.
- Push:
  - Accepted on a rising edge with i_Tx_DV=1 and o_Tx_Ready=1; count increments at that edge.
  - i_Tx_DV=1 while full is dropped silently; count and contents are unchanged.
  - o_Tx_Ready = (count != FIFO_DEPTH), combinational from count.
- Push and pop on the same edge: count unchanged, both operations take effect. Because of the ready gating, a push is still refused if count was full before that edge.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: o_Tx_Serial=1, o_Tx_Active=0. If count>0, pop the head into the shift register, reset the clock counter and go to START on the same edge.
  - START: o_Tx_Serial=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: o_Tx_Serial=shift[index], LSB first, each bit held CLKS_PER_BIT cycles. After index 7 completes, go to STOP.
  - STOP: o_Tx_Serial=1 for CLKS_PER_BIT cycles. o_Tx_Done=1 on the last of these cycles. Then:
    - if count>0, pop and go directly to START (no idle gap between frames);
    - else go to IDLE.
- o_Tx_Active=1 in START, DATA and STOP.
- Latency: with the FIFO empty and the FSM in IDLE, a push at edge N makes count=1. The pop happens at edge N+1 and o_Tx_Serial goes low from edge N+1.
- Frame length: exactly 10*CLKS_PER_BIT cycles, measured from the start-bit falling edge to the next possible start-bit falling edge.
- Counter rules:
  - clock counter width is $clog2(CLKS_PER_BIT); it counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
- Changes to i_Tx_Byte after acceptance never affect a queued or in-flight byte.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding localparams IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3;
  - UART_DATA_BITS=8.
- Sub-module sync_fifo (parameters WIDTH=8, DEPTH=FIFO_DEPTH):
  - ports: push/pop, full/empty, count, head data with show-ahead read;
  - same i_Clock/i_Reset style.
- The FSM and bit timer stay in uart_tx_fifo.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset released, no pushes -> o_Tx_Serial=1, o_Tx_Ready=1, o_Fifo_Count=0, o_Tx_Active=0 for 100 cycles.
- Push 0x55 in IDLE -> line falls at the next edge, then 0,1,0,1,0,1,0,1,0,1, each held 4 cycles. o_Tx_Done pulses once at frame cycle 40, then o_Tx_Active=0.
- Push 0xA3 and 0x0F on consecutive cycles -> two back-to-back frames, 80 cycles total, with no idle-high gap between the stop bit of 0xA3 and the start bit of 0x0F. LSB-first decode yields 0xA3 then 0x0F.
- Push 6 bytes 0x01..0x06 on consecutive cycles from IDLE:
  - 0x01 is popped at the edge after its push;
  - 0x02..0x05 fill the FIFO, count=4, o_Tx_Ready=0;
  - 0x06 is dropped;
  - the line carries 0x01..0x05 only.
- Push while full in the same cycle STOP pops -> push refused, count goes 4 to 3, and the next push is accepted.
- Assert i_Reset low mid-DATA of 0xFF with 2 bytes queued -> o_Tx_Serial=1 and count=0 without waiting for a clock edge. After release, no frame is emitted for 200 cycles.
